// File: rtl/bwt_pkg.sv
// ---------------------------------------------------------------------------
// bwt_pkg
// Shared types and constants for the BWT merge-sort datapath. Used by the
// run pre-sort stage and by the downstream two-FIFO merge stage.
//   BYTE_W       : width of one symbol on every byte path
//   bwt_state_t  : IDLE / LOAD / SORT / DRAIN control states
//   fifo_sel_t   : which of the two run FIFOs a run belongs to (L=0, R=1)
// ---------------------------------------------------------------------------
package bwt_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SORT  = 2'd2,
    DRAIN = 2'd3
  } bwt_state_t;

  typedef enum logic {
    SEL_L = 1'b0,
    SEL_R = 1'b1
  } fifo_sel_t;

  // Runs alternate between the two FIFOs; this gives the FIFO for the next run.
  function automatic fifo_sel_t other_fifo(input fifo_sel_t sel);
    return (sel == SEL_L) ? SEL_R : SEL_L;
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// ---------------------------------------------------------------------------
// cmp_swap
// Purely combinational compare-exchange element for the transposition sorter.
//   a, b   : input bytes (unsigned)
//   lo, hi : min(a,b), max(a,b)
// Equal inputs pass straight through (no swap).
// ---------------------------------------------------------------------------
module cmp_swap
  import bwt_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] lo,
  output logic [BYTE_W-1:0] hi
);

  logic swap;

  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/run_presort.sv
// ---------------------------------------------------------------------------
// run_presort
// First stage of the BWT merge sort. Cuts the incoming byte stream into runs
// of RUN_LEN bytes, sorts each run ascending with an odd-even transposition
// network over a local register array, and writes the sorted runs into the
// left / right FIFOs alternately (L, R, L, R, ...). A job is NUM_RUNS runs.
//
// Ports
//   clk, rst_n              : clock (rising edge), async active-low reset
//   start                   : one-cycle job start, only honoured when idle
//   in_data/in_valid/in_ready : input byte stream handshake
//   fifo_l_full/fifo_r_full : FIFO full flags, sampled in the same cycle
//   wr_data                 : byte for the shared FIFO write port
//   wr_fifo_l/wr_fifo_r     : write strobes, mutually exclusive
//   busy                    : job in progress
//   done                    : one-cycle pulse on the first idle cycle after
//                             the last byte of the last run is written
// ---------------------------------------------------------------------------
module run_presort
  import bwt_pkg::*;
#(
  parameter int RUN_LEN  = 4,
  parameter int NUM_RUNS = 2,
  parameter int CNT_W    = $clog2(RUN_LEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fifo_l_full,
  input  logic              fifo_r_full,
  output logic [BYTE_W-1:0] wr_data,
  output logic              wr_fifo_l,
  output logic              wr_fifo_r,
  output logic              busy,
  output logic              done
);

  // Array addressing uses only the low bits of the counters; the extra
  // counter bit exists so the counters can be compared against RUN_LEN-1
  // without wrap concerns.
  localparam int IDX_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam int RC_W  = $clog2(NUM_RUNS) + 1;
  localparam int HALF  = RUN_LEN / 2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RUN_LEN - 1);
  localparam logic [RC_W-1:0]  LAST_RUN = RC_W'(NUM_RUNS - 1);

  bwt_state_t       state_reg, state_next;
  logic [CNT_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] pass_reg, pass_next;
  logic [RC_W-1:0]  run_cnt_reg, run_cnt_next;
  fifo_sel_t        sel_reg, sel_next;
  logic             done_reg, done_next;

  logic [BYTE_W-1:0] run_buf_reg  [RUN_LEN];
  logic [BYTE_W-1:0] run_buf_next [RUN_LEN];

  // Results of one even pass and one odd pass applied to the current buffer.
  logic [BYTE_W-1:0] even_res [RUN_LEN];
  logic [BYTE_W-1:0] odd_res  [RUN_LEN];

  logic [BYTE_W-1:0] drain_byte;
  logic              wr_any;

  // -------------------------------------------------------------------------
  // Transposition network: even pass pairs (0,1),(2,3)...; odd pass pairs
  // (1,2),(3,4)... with the two end elements passing through unchanged.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < HALF; gi++) begin : g_even
      cmp_swap u_cs (
        .a  (run_buf_reg[2*gi]),
        .b  (run_buf_reg[2*gi+1]),
        .lo (even_res[2*gi]),
        .hi (even_res[2*gi+1])
      );
    end

    for (gi = 0; gi < HALF - 1; gi++) begin : g_odd
      cmp_swap u_cs (
        .a  (run_buf_reg[2*gi+1]),
        .b  (run_buf_reg[2*gi+2]),
        .lo (odd_res[2*gi+1]),
        .hi (odd_res[2*gi+2])
      );
    end
  endgenerate

  assign odd_res[0]         = run_buf_reg[0];
  assign odd_res[RUN_LEN-1] = run_buf_reg[RUN_LEN-1];

  assign drain_byte = run_buf_reg[idx_reg[IDX_W-1:0]];
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;

  // -------------------------------------------------------------------------
  // Next-state, next-data and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pass_next    = pass_reg;
    run_cnt_next = run_cnt_reg;
    sel_next     = sel_reg;
    done_next    = 1'b0;
    for (int k = 0; k < RUN_LEN; k++) begin
      run_buf_next[k] = run_buf_reg[k];
    end
    in_ready  = 1'b0;
    wr_data   = '0;
    wr_fifo_l = 1'b0;
    wr_fifo_r = 1'b0;
    wr_any    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = LOAD;
          idx_next     = '0;
          run_cnt_next = '0;
          sel_next     = SEL_L;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          run_buf_next[idx_reg[IDX_W-1:0]] = in_data;
          if (idx_reg == LAST_IDX) begin
            state_next = SORT;
            pass_next  = '0;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      SORT: begin
        // RUN_LEN alternating passes are enough for any input order.
        for (int k = 0; k < RUN_LEN; k++) begin
          run_buf_next[k] = pass_reg[0] ? odd_res[k] : even_res[k];
        end
        if (pass_reg == LAST_IDX) begin
          state_next = DRAIN;
          idx_next   = '0;
        end else begin
          pass_next = pass_reg + 1'b1;
        end
      end

      DRAIN: begin
        wr_data   = drain_byte;
        wr_fifo_l = (sel_reg == SEL_L) && !fifo_l_full;
        wr_fifo_r = (sel_reg == SEL_R) && !fifo_r_full;
        wr_any    = wr_fifo_l || wr_fifo_r;
        // A full FIFO simply holds idx; the same byte is offered again.
        if (wr_any) begin
          if (idx_reg == LAST_IDX) begin
            sel_next     = other_fifo(sel_reg);
            run_cnt_next = run_cnt_reg + 1'b1;
            idx_next     = '0;
            if (run_cnt_reg < LAST_RUN) begin
              state_next = LOAD;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      pass_reg    <= '0;
      run_cnt_reg <= '0;
      sel_reg     <= SEL_L;
      done_reg    <= 1'b0;
      for (int k = 0; k < RUN_LEN; k++) begin
        run_buf_reg[k] <= '0;
      end
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pass_reg    <= pass_next;
      run_cnt_reg <= run_cnt_next;
      sel_reg     <= sel_next;
      done_reg    <= done_next;
      for (int k = 0; k < RUN_LEN; k++) begin
        run_buf_reg[k] <= run_buf_next[k];
      end
    end
  end

endmodule

// File: tb/tb_run_presort.sv
// ---------------------------------------------------------------------------
// tb_run_presort
// Scoreboard bench for run_presort (RUN_LEN=4, NUM_RUNS=2). Stimulus pushes
// the hand-sorted expected bytes for each run into per-FIFO queues; a
// negedge monitor pops and compares on every write strobe.
// ---------------------------------------------------------------------------
module tb_run_presort;
  import bwt_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       fifo_l_full;
  logic       fifo_r_full;
  logic [7:0] wr_data;
  logic       wr_fifo_l;
  logic       wr_fifo_r;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  run_presort #(
    .RUN_LEN  (4),
    .NUM_RUNS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fifo_l_full (fifo_l_full),
    .fifo_r_full (fifo_r_full),
    .wr_data     (wr_data),
    .wr_fifo_l   (wr_fifo_l),
    .wr_fifo_r   (wr_fifo_r),
    .busy        (busy),
    .done        (done)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_l[$];
  logic [7:0] exp_r[$];
  logic [7:0] exp_d;

  int done_cnt      = 0;
  int busy_cycles   = 0;
  int l_stall_cycles = 0;
  int r_stall_cycles = 0;
  logic stall_l_arm = 1'b0;
  logic stall_r_arm = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (done) done_cnt++;
    if (busy && fifo_l_full) l_stall_cycles++;
    if (busy && fifo_r_full) r_stall_cycles++;
    if (wr_fifo_l && wr_fifo_r) chk("both_strobes", 32'd1, 32'd0);
    if (wr_fifo_l) begin
      chk("l_write_while_full", {31'd0, fifo_l_full}, 32'd0);
      if (exp_l.size() == 0) begin
        checks++; errors++;
        $display("FAIL l_unexpected_write: got %0d required no write", wr_data);
      end else begin
        exp_d = exp_l.pop_front();
        chk("l_data", {24'd0, wr_data}, {24'd0, exp_d});
      end
    end
    if (wr_fifo_r) begin
      chk("r_write_while_full", {31'd0, fifo_r_full}, 32'd0);
      if (exp_r.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected_write: got %0d required no write", wr_data);
      end else begin
        exp_d = exp_r.pop_front();
        chk("r_data", {24'd0, wr_data}, {24'd0, exp_d});
      end
    end
  end

  // ---------------- backpressure drivers ----------------
  initial forever begin
    @(negedge clk);
    if (stall_l_arm && wr_fifo_l) begin
      @(posedge clk); #1;
      fifo_l_full = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      fifo_l_full = 1'b0;
      stall_l_arm = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (stall_r_arm && wr_fifo_r) begin
      @(posedge clk); #1;
      fifo_r_full = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      fifo_r_full = 1'b0;
      stall_r_arm = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] el, input logic [31:0] er);
    for (int i = 0; i < 4; i++) begin
      exp_l.push_back(el[31-8*i -: 8]);
      exp_r.push_back(er[31-8*i -: 8]);
    end
  endtask

  task automatic finish_job(input string tag, input int d0);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: got 0 required 1", tag);
    end else begin
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
    chk({tag, "_l_left"}, exp_l.size(), 32'd0);
    chk({tag, "_r_left"}, exp_r.size(), 32'd0);
  endtask

  task automatic run_job(input logic [63:0] d, input logic [31:0] el,
                         input logic [31:0] er, input bit gap, input string tag);
    int d0;
    d0 = done_cnt;
    push_exp(el, er);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(d[63-8*i -: 8], gap);
    finish_job(tag, d0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    rst_n       = 1'b0;
    start       = 1'b1;   // activity during reset must be ignored
    in_valid    = 1'b1;
    in_data     = 8'h55;
    fifo_l_full = 1'b0;
    fifo_r_full = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_l", {31'd0, wr_fifo_l}, 32'd0);
    chk("rst_wr_r", {31'd0, wr_fifo_r}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    // Basic job, 4+4+4 cycles per run
    busy_cycles = 0;
    run_job(64'h07030901_040400FF, 32'h01030709, 32'h000404FF, 1'b0, "basic");
    chk("basic_busy_cycles", busy_cycles, 32'd24);

    // Backpressure on both FIFOs mid-drain
    l_stall_cycles = 0;
    r_stall_cycles = 0;
    stall_l_arm = 1'b1;
    stall_r_arm = 1'b1;
    run_job(64'h05020806_09010307, 32'h02050608, 32'h01030709, 1'b0, "bp");
    chk("bp_l_stall_cycles", l_stall_cycles, 32'd3);
    chk("bp_r_stall_cycles", r_stall_cycles, 32'd5);

    // in_valid dropped every other cycle
    run_job(64'h07030901_040400FF, 32'h01030709, 32'h000404FF, 1'b1, "gaps");

    // Reverse-ordered run: worst case for transposition sort
    busy_cycles = 0;
    run_job(64'hFF800200_80FF0002, 32'h000280FF, 32'h000280FF, 1'b0, "rev");
    chk("rev_busy_cycles", busy_cycles, 32'd24);

    // Reset mid-SORT abandons the job
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    chk("sort_busy_before_rst", {31'd0, busy}, 32'd1);
    chk("sort_in_ready_before_rst", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_strobes", {30'd0, wr_fifo_l, wr_fifo_r}, 32'd0);
    chk("midrst_wr_data", {24'd0, wr_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    @(posedge clk); #1;
    run_job(64'h06050403_01010200, 32'h03040506, 32'h00010102, 1'b0, "post_rst");

    // start during DRAIN and in_valid held through SORT are ignored
    d0 = done_cnt;
    push_exp(32'h00010203, 32'h06070809);
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sort_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h09, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h06, 1'b0);
    finish_job("ignore", d0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("ignore_stays_idle", {31'd0, busy}, 32'd0);
    chk("ignore_single_done", done_cnt - d0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
